// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolution, E/GT flags and a 32-step signed divider.
// All state advances on the falling edge of clk, in step with the pipeline latches.
module ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] input_EX_PC,
   input  logic [31:0] EX_branchTarget,
   input  logic [31:0] Operand_EX_A,
   input  logic [31:0] Operand_EX_B,
   input  logic [31:0] Operand_EX_2,
   input  logic [31:0] input_EX_IR,
   input  logic [21:0] Input_EX_controlBus,
   output logic        isBranchTaken,
   output logic [31:0] branchPC,
   output logic        exStall,
   output logic [31:0] input_MA_PC,
   output logic [31:0] ALU_result,
   output logic [31:0] Operand_MA_2,
   output logic [31:0] input_MA_IR,
   output logic [21:0] Input_MA_controlBus
);

   typedef enum logic [4:0] {
      OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3,
      OP_MOD = 5'd4,  OP_CMP = 5'd5,  OP_AND = 5'd6,  OP_OR  = 5'd7,
      OP_NOT = 5'd8,  OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR = 5'd11,
      OP_ASR = 5'd12, OP_NOP = 5'd13, OP_LD  = 5'd14, OP_ST  = 5'd15,
      OP_BEQ = 5'd16, OP_BGT = 5'd17, OP_B   = 5'd18, OP_CALL = 5'd19,
      OP_RET = 5'd20
   } opcode_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   typedef struct packed {
      logic e;
      logic gt;
   } flags_t;

   localparam logic [31:0] NOP_IR = 32'h6800_0000;

   opcode_t    opcode;
   logic       is_divmod;
   flags_t     flags;
   div_state_t div_state;
   logic [4:0] div_count;
   logic [31:0] div_rem, div_quo, div_dvsr, div_a;
   logic        div_q_neg, div_r_neg, div_by_zero;
   logic [31:0] alu_out;

   assign opcode    = opcode_t'(input_EX_IR[31:27]);
   assign is_divmod = (opcode == OP_DIV) || (opcode == OP_MOD);
   assign exStall   = !reset && is_divmod && (div_state != DONE);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      alu_out = '0;
      case (opcode)
         OP_ADD, OP_LD, OP_ST: alu_out = Operand_EX_A + Operand_EX_B;
         OP_SUB:  alu_out = Operand_EX_A - Operand_EX_B;
         OP_MUL:  alu_out = Operand_EX_A * Operand_EX_B;
         OP_AND:  alu_out = Operand_EX_A & Operand_EX_B;
         OP_OR:   alu_out = Operand_EX_A | Operand_EX_B;
         OP_NOT:  alu_out = ~Operand_EX_B;
         OP_MOV:  alu_out = Operand_EX_B;
         OP_LSL:  alu_out = Operand_EX_A << Operand_EX_B[4:0];
         OP_LSR:  alu_out = Operand_EX_A >> Operand_EX_B[4:0];
         OP_ASR:  alu_out = $unsigned($signed(Operand_EX_A) >>> Operand_EX_B[4:0]);
         OP_CALL: alu_out = input_EX_PC + 32'd4;
         default: alu_out = '0;
      endcase
   end

   always_comb begin
      isBranchTaken = (opcode == OP_B) || (opcode == OP_CALL) || (opcode == OP_RET)
                    || ((opcode == OP_BEQ) && flags.e)
                    || ((opcode == OP_BGT) && flags.gt);
      branchPC      = (opcode == OP_RET) ? Operand_EX_A : EX_branchTarget;
   end

   // One restoring step: the 33-bit trial subtraction borrows exactly when the divisor does not fit.
   logic [32:0] rem_shift, rem_trial;
   logic        step_fits;
   logic [31:0] a_mag, b_mag, quo_final, rem_final, div_result;

   always_comb begin
      rem_shift  = {div_rem, div_quo[31]};
      rem_trial  = rem_shift - {1'b0, div_dvsr};
      step_fits  = !rem_trial[32];
      a_mag      = Operand_EX_A[31] ? -Operand_EX_A : Operand_EX_A;
      b_mag      = Operand_EX_B[31] ? -Operand_EX_B : Operand_EX_B;
      quo_final  = div_by_zero ? 32'hFFFF_FFFF : (div_q_neg ? -div_quo : div_quo);
      rem_final  = div_by_zero ? div_a : (div_r_neg ? -div_rem : div_rem);
      div_result = (opcode == OP_MOD) ? rem_final : quo_final;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(negedge clk) begin
      if (reset) begin
         input_MA_PC         <= '0;
         ALU_result          <= '0;
         Operand_MA_2        <= '0;
         input_MA_IR         <= NOP_IR;
         Input_MA_controlBus <= '0;
         flags               <= '0;
         div_state           <= IDLE;
         div_count           <= '0;
      end else if (exStall) begin
         input_MA_PC         <= '0;
         ALU_result          <= '0;
         Operand_MA_2        <= '0;
         input_MA_IR         <= NOP_IR;
         Input_MA_controlBus <= '0;
         if (div_state == IDLE) begin
            div_rem     <= '0;
            div_quo     <= a_mag;
            div_dvsr    <= b_mag;
            div_a       <= Operand_EX_A;
            div_q_neg   <= Operand_EX_A[31] ^ Operand_EX_B[31];
            div_r_neg   <= Operand_EX_A[31];
            div_by_zero <= (Operand_EX_B == '0);
            div_count   <= '0;
            div_state   <= BUSY;
         end else begin
            div_rem   <= step_fits ? rem_trial[31:0] : rem_shift[31:0];
            div_quo   <= {div_quo[30:0], step_fits};
            div_count <= div_count + 5'd1;
            if (div_count == 5'd31) div_state <= DONE;
         end
      end else begin
         input_MA_PC         <= input_EX_PC;
         ALU_result          <= is_divmod ? div_result : alu_out;
         Operand_MA_2        <= Operand_EX_2;
         input_MA_IR         <= input_EX_IR;
         Input_MA_controlBus <= Input_EX_controlBus;
         if (opcode == OP_CMP) begin
            flags.e  <= (Operand_EX_A == Operand_EX_B);
            flags.gt <= ($signed(Operand_EX_A) > $signed(Operand_EX_B));
         end
         if (div_state == DONE) div_state <= IDLE;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU, flags/branches, divider timing and corner cases.
module tb_ex_stage;

   localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3,
                          OP_MOD = 5'd4,  OP_CMP = 5'd5,  OP_ASR = 5'd12, OP_NOP = 5'd13,
                          OP_BEQ = 5'd16, OP_BGT = 5'd17, OP_CALL = 5'd19, OP_RET = 5'd20;
   localparam logic [31:0] NOP_IR = 32'h6800_0000;
   localparam logic [21:0] CTRL   = 22'h2A5A5;
   localparam logic [31:0] ST_DAT = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] input_EX_PC = '0, EX_branchTarget = '0, Operand_EX_A = '0, Operand_EX_B = '0;
   logic [31:0] Operand_EX_2 = '0, input_EX_IR = NOP_IR;
   logic [21:0] Input_EX_controlBus = '0;
   logic        isBranchTaken, exStall;
   logic [31:0] branchPC, input_MA_PC, ALU_result, Operand_MA_2, input_MA_IR;
   logic [21:0] Input_MA_controlBus;

   int total = 0;
   int bad   = 0;

   ex_stage dut (
      .clk(clk), .reset(reset),
      .input_EX_PC(input_EX_PC), .EX_branchTarget(EX_branchTarget),
      .Operand_EX_A(Operand_EX_A), .Operand_EX_B(Operand_EX_B), .Operand_EX_2(Operand_EX_2),
      .input_EX_IR(input_EX_IR), .Input_EX_controlBus(Input_EX_controlBus),
      .isBranchTaken(isBranchTaken), .branchPC(branchPC), .exStall(exStall),
      .input_MA_PC(input_MA_PC), .ALU_result(ALU_result), .Operand_MA_2(Operand_MA_2),
      .input_MA_IR(input_MA_IR), .Input_MA_controlBus(Input_MA_controlBus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change 1 time unit after a falling edge; the DUT samples on the next falling edge.
   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] tgt);
      input_EX_IR         = {op, 27'h0000ABC};
      Operand_EX_A        = a;
      Operand_EX_B        = b;
      input_EX_PC         = pc;
      EX_branchTarget     = tgt;
      Operand_EX_2        = ST_DAT;
      Input_EX_controlBus = CTRL;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(OP_NOP, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      total++; if (input_MA_IR !== NOP_IR) begin bad++; $display("FAIL reset_ir got=%h exp=%h", input_MA_IR, NOP_IR); end
      total++; if (ALU_result !== 32'h0) begin bad++; $display("FAIL reset_alu got=%h exp=0", ALU_result); end
      total++; if (isBranchTaken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", isBranchTaken); end
      total++; if (exStall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", exStall); end
      reset = 1'b0;
   endtask

   task automatic test_alu();
      drive(OP_ADD, 32'd7, 32'd5, 32'h0000_0200, 0);
      #1;
      total++; if (exStall !== 1'b0) begin bad++; $display("FAIL add_stall got=%b exp=0", exStall); end
      step();
      total++; if (ALU_result !== 32'd12) begin bad++; $display("FAIL add got=%h exp=%h", ALU_result, 32'd12); end
      total++; if (input_MA_IR !== {OP_ADD, 27'h0000ABC} || input_MA_PC !== 32'h200
                   || Operand_MA_2 !== ST_DAT || Input_MA_controlBus !== CTRL) begin
         bad++; $display("FAIL passthru got ir=%h pc=%h d=%h c=%h", input_MA_IR, input_MA_PC, Operand_MA_2, Input_MA_controlBus);
      end
      drive(OP_SUB, 32'd3, 32'd5, 0, 0);
      step();
      total++; if (ALU_result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub got=%h exp=fffffffe", ALU_result); end
      drive(OP_MUL, 32'd3, 32'hFFFF_FFFE, 0, 0);
      step();
      total++; if (ALU_result !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mul got=%h exp=fffffffa", ALU_result); end
      drive(OP_ASR, 32'h8000_0000, 32'h0000_0024, 0, 0);
      step();
      total++; if (ALU_result !== 32'hF800_0000) begin bad++; $display("FAIL asr got=%h exp=f8000000", ALU_result); end
      drive(OP_CALL, 0, 0, 32'h0000_0100, 32'h0000_0800);
      #1;
      total++; if (isBranchTaken !== 1'b1 || branchPC !== 32'h800) begin
         bad++; $display("FAIL call_br got taken=%b pc=%h exp 1/800", isBranchTaken, branchPC);
      end
      step();
      total++; if (ALU_result !== 32'h104) begin bad++; $display("FAIL call_link got=%h exp=104", ALU_result); end
   endtask

   task automatic test_branch();
      drive(OP_CMP, 32'd4, 32'd4, 0, 0);
      step();
      total++; if (ALU_result !== 32'h0) begin bad++; $display("FAIL cmp_alu got=%h exp=0", ALU_result); end
      drive(OP_BEQ, 0, 0, 0, 32'h40);
      #1;
      total++; if (isBranchTaken !== 1'b1 || branchPC !== 32'h40) begin
         bad++; $display("FAIL beq_taken got taken=%b pc=%h exp 1/40", isBranchTaken, branchPC);
      end
      step();
      drive(OP_CMP, 32'hFFFF_FFFF, 32'd1, 0, 0);
      step();
      drive(OP_BGT, 0, 0, 0, 32'h40);
      #1;
      total++; if (isBranchTaken !== 1'b0) begin bad++; $display("FAIL bgt_signed got=%b exp=0", isBranchTaken); end
      drive(OP_BEQ, 0, 0, 0, 32'h40);
      #1;
      total++; if (isBranchTaken !== 1'b0) begin bad++; $display("FAIL beq_cleared got=%b exp=0", isBranchTaken); end
      step();
      drive(OP_CMP, 32'd5, 32'hFFFF_FFFB, 0, 0);
      step();
      drive(OP_BGT, 0, 0, 0, 32'h80);
      #1;
      total++; if (isBranchTaken !== 1'b1 || branchPC !== 32'h80) begin
         bad++; $display("FAIL bgt_taken got taken=%b pc=%h exp 1/80", isBranchTaken, branchPC);
      end
      step();
   endtask

   task automatic test_divide(input string name, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
      int stall_cnt = 0;
      int bubble_err = 0;
      drive(op, a, b, 32'h300, 0);
      #1;
      for (int i = 0; i < 100; i++) begin
         if (!exStall) break;
         stall_cnt++;
         step();
         if (input_MA_IR !== NOP_IR || ALU_result !== 32'h0 || Input_MA_controlBus !== 22'h0) bubble_err++;
      end
      total++; if (stall_cnt != 33) begin bad++; $display("FAIL %s_stall_cycles got=%0d exp=33", name, stall_cnt); end
      total++; if (bubble_err != 0) begin bad++; $display("FAIL %s_bubble got=%0d bad cycles exp=0", name, bubble_err); end
      step();
      total++; if (ALU_result !== exp || input_MA_IR !== {op, 27'h0000ABC}) begin
         bad++; $display("FAIL %s got=%h ir=%h exp=%h", name, ALU_result, input_MA_IR, exp);
      end
      drive(OP_NOP, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_div();
      drive(OP_DIV, 32'd1000, 32'd3, 0, 0);
      repeat (11) @(negedge clk);
      #1;
      total++; if (exStall !== 1'b1) begin bad++; $display("FAIL mid_busy_stall got=%b exp=1", exStall); end
      reset = 1'b1;
      #1;
      total++; if (exStall !== 1'b0) begin bad++; $display("FAIL mid_reset_stall got=%b exp=0", exStall); end
      step();
      total++; if (input_MA_IR !== NOP_IR || ALU_result !== 32'h0) begin
         bad++; $display("FAIL mid_reset_bubble got ir=%h alu=%h exp %h/0", input_MA_IR, ALU_result, NOP_IR);
      end
      drive(OP_NOP, 0, 0, 0, 0);
      reset = 1'b0;
      step();
      test_divide("div_after_reset", OP_DIV, 32'd100, 32'd7, 32'd14);
      drive(OP_RET, 32'h100, 0, 0, 32'h40);
      #1;
      total++; if (isBranchTaken !== 1'b1 || branchPC !== 32'h100) begin
         bad++; $display("FAIL ret got taken=%b pc=%h exp 1/100", isBranchTaken, branchPC);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_divide("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      test_divide("mod_neg", OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      test_divide("div_zero", OP_DIV, 32'd9, 32'd0, 32'hFFFF_FFFF);
      test_divide("mod_zero", OP_MOD, 32'd9, 32'd0, 32'd9);
      test_divide("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      test_divide("mod_ovf", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
      test_reset_mid_div();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
